// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//
// Purpose:
//   Pipeline register placed between two adjacent pipeline stages. It carries
//   a control bundle and a data bundle under a valid/ready handshake. A
//   two-entry arrangement (main + skid) lets back-pressure propagate without
//   a combinational ready path. A synchronous flush turns every held entry
//   into a bubble.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   flush      synchronous kill of all held entries
//   in_valid   upstream has an entry
//   in_ready   stage can accept (registered)
//   in_ctrl    upstream control bundle
//   in_data    upstream data bundle
//   out_valid  stage presents an entry
//   out_ready  downstream accepts
//   out_ctrl   control bundle, all-zero whenever out_valid=0
//   out_data   data bundle, holds its last value when out_valid=0
//   stall_cnt  cycles with out_valid & !out_ready (saturating)
//   bubble_cnt cycles with !out_valid (saturating)
//
// Configuration macro:
//   PIPE_STAGE_PERF_EN  when defined, the performance counters are built;
//                       otherwise stall_cnt and bubble_cnt are tied to 0.

module pipe_stage_reg #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 96,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              mainValid;
  logic [CTRL_W-1:0] mainCtrl;
  logic [DATA_W-1:0] mainData;
  logic              skidValid;
  logic [CTRL_W-1:0] skidCtrl;
  logic [DATA_W-1:0] skidData;
  logic              inHs;
  logic              outHs;

  // The skid register only ever fills while the main register is full, so
  // skidValid alone tells us the stage holds two entries. in_ready is the
  // inverse of that flop and never sees out_ready combinationally.
  assign in_ready = !skidValid;
  assign inHs     = in_valid & in_ready;
  assign outHs    = mainValid & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mainValid <= 1'b0;
      mainCtrl  <= '0;
      mainData  <= '0;
      skidValid <= 1'b0;
      skidCtrl  <= '0;
      skidData  <= '0;
    end else if (flush) begin
      // Payload registers keep their contents; only the valid bits die.
      mainValid <= 1'b0;
      skidValid <= 1'b0;
    end else if (!mainValid || outHs) begin
      if (skidValid) begin
        // Older skid entry goes first to keep strict FIFO order.
        mainValid <= 1'b1;
        mainCtrl  <= skidCtrl;
        mainData  <= skidData;
        if (inHs) begin
          skidCtrl <= in_ctrl;
          skidData <= in_data;
        end else begin
          skidValid <= 1'b0;
        end
      end else if (inHs) begin
        mainValid <= 1'b1;
        mainCtrl  <= in_ctrl;
        mainData  <= in_data;
      end else begin
        mainValid <= 1'b0;
      end
    end else if (inHs) begin
      skidValid <= 1'b1;
      skidCtrl  <= in_ctrl;
      skidData  <= in_data;
    end
  end

  assign out_valid = mainValid;
  assign out_ctrl  = mainValid ? mainCtrl : '0;
  assign out_data  = mainData;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] bubbleCnt;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stallCnt  <= '0;
      bubbleCnt <= '0;
    end else begin
      if (mainValid && !out_ready) stallCnt <= satInc(stallCnt);
      if (!mainValid) bubbleCnt <= satInc(bubbleCnt);
    end
  end

  assign stall_cnt  = stallCnt;
  assign bubble_cnt = bubbleCnt;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: directed stimulus, a queue-based reference
// model checked every cycle, and literal spot checks.

module tb_pipe_stage_reg;

  localparam int CTRL_W = 4;
  localparam int DATA_W = 96;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the stage is a FIFO of at most two entries.
  typedef struct {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              q[$];
  logic [DATA_W-1:0] lastData = '0;
  int                stallM = 0;
  int                bubbleM = 0;
  int                nTests = 0;
  int                nFail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic modelClear();
    q.delete();
    lastData = '0;
    stallM = 0;
    bubbleM = 0;
  endtask

  // Apply one cycle of stimulus, let the edge happen, advance the model.
  task automatic tick(input logic iv, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                      input logic ordy, input logic fl);
    bit ihs, ohs, stl, bub;
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    ihs = iv && (q.size() < 2);
    ohs = (q.size() > 0) && ordy;
    stl = (q.size() > 0) && !ordy;
    bub = (q.size() == 0);
    @(posedge clk);
`ifdef PIPE_STAGE_PERF_EN
    if (stl && stallM < CNT_MAX) stallM++;
    if (bub && bubbleM < CNT_MAX) bubbleM++;
`endif
    if (fl) q.delete();
    else begin
      if (ohs) void'(q.pop_front());
      if (ihs) q.push_back('{c, d});
    end
    if (q.size() > 0) lastData = q[0].d;
    #2;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("m_out_valid", out_valid, q.size() > 0);
      chk("m_in_ready", in_ready, q.size() < 2);
      chk("m_out_ctrl", out_ctrl, (q.size() > 0) ? q[0].c : '0);
      chk("m_out_data", out_data, lastData);
      chk("m_stall_cnt", stall_cnt, stallM);
      chk("m_bubble_cnt", bubble_cnt, bubbleM);
    end
  end

  initial begin
    modelClear();
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_ctrl", out_ctrl, 4'h0);
    chk("rst_out_data", out_data, 96'h0);
    chk("rst_stall", stall_cnt, 4'h0);
    reset_n = 1'b1;

    // Streaming: 1..10, each visible one edge after it is offered.
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1, 4'(i), 96'(i), 1'b1, 1'b0);
      chk("stream_data", out_data, 96'(i));
      chk("stream_ready", in_ready, 1'b1);
    end
    tick(1'b0, 4'h0, 96'h0, 1'b1, 1'b0);
    chk("stream_end_valid", out_valid, 1'b0);

    // Bubble control kill.
    tick(1'b1, 4'hF, 96'hABC, 1'b1, 1'b0);
    chk("kill_ctrl_live", out_ctrl, 4'hF);
    tick(1'b0, 4'h0, 96'h0, 1'b1, 1'b0);
    chk("kill_ctrl_zero", out_ctrl, 4'h0);
    chk("kill_data_hold", out_data, 96'hABC);

    // Back-pressure.
    tick(1'b1, 4'h1, 96'hA, 1'b0, 1'b0);
    chk("bp_A_shown", out_data, 96'hA);
    chk("bp_ready_1", in_ready, 1'b1);
    tick(1'b1, 4'h2, 96'hB, 1'b0, 1'b0);
    chk("bp_ready_0", in_ready, 1'b0);
    chk("bp_A_held", out_data, 96'hA);
    tick(1'b1, 4'h7, 96'h77, 1'b0, 1'b0);
    chk("bp_still_A", out_data, 96'hA);
    tick(1'b0, 4'h0, 96'h0, 1'b1, 1'b0);
    chk("bp_B_shown", out_data, 96'hB);
    chk("bp_ready_back", in_ready, 1'b1);
    tick(1'b0, 4'h0, 96'h0, 1'b1, 1'b0);
    chk("bp_drained", out_valid, 1'b0);

    // Flush with a held entry, out_hs and in_hs all in the same cycle.
    tick(1'b1, 4'h3, 96'hC, 1'b0, 1'b0);
    tick(1'b1, 4'h5, 96'hE, 1'b1, 1'b1);
    chk("fl1_valid", out_valid, 1'b0);
    chk("fl1_ctrl", out_ctrl, 4'h0);
    chk("fl1_ready", in_ready, 1'b1);
    chk("fl1_data_hold", out_data, 96'hC);
    tick(1'b0, 4'h0, 96'h0, 1'b1, 1'b0);
    chk("fl1_no_ghost", out_valid, 1'b0);

    // Flush with both entries full.
    tick(1'b1, 4'h3, 96'hC, 1'b0, 1'b0);
    tick(1'b1, 4'h4, 96'hD, 1'b0, 1'b0);
    chk("fl2_full", in_ready, 1'b0);
    tick(1'b0, 4'h0, 96'h0, 1'b0, 1'b1);
    chk("fl2_valid", out_valid, 1'b0);
    chk("fl2_ready", in_ready, 1'b1);
    tick(1'b0, 4'h0, 96'h0, 1'b1, 1'b0);
    chk("fl2_no_ghost", out_valid, 1'b0);

    // Counters: fresh reset, one entry, then 20 stalled cycles.
    #1 reset_n = 1'b0;
    modelClear();
    #1 reset_n = 1'b1;
    tick(1'b1, 4'h1, 96'h1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b0, 4'h0, 96'h0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
    chk("cnt_stall_sat", stall_cnt, 4'd15);
    chk("cnt_bubble", bubble_cnt, 4'd1);
`else
    chk("cnt_stall_off", stall_cnt, 4'd0);
    chk("cnt_bubble_off", bubble_cnt, 4'd0);
`endif

    // Asynchronous reset mid-stall with skid full.
    tick(1'b1, 4'h2, 96'h2, 1'b0, 1'b0);
    chk("ar_skid_full", in_ready, 1'b0);
    #1 reset_n = 1'b0;
    modelClear();
    #1;
    chk("ar_out_valid", out_valid, 1'b0);
    chk("ar_in_ready", in_ready, 1'b1);
    chk("ar_out_ctrl", out_ctrl, 4'h0);
    chk("ar_out_data", out_data, 96'h0);
    chk("ar_stall", stall_cnt, 4'h0);
    chk("ar_bubble", bubble_cnt, 4'h0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    tick(1'b1, 4'h9, 96'h99, 1'b1, 1'b0);
    chk("post_rst_data", out_data, 96'h99);
    tick(1'b0, 4'h0, 96'h0, 1'b1, 1'b0);
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
